// File: rtl/rng_harvester.sv
// Consumer side of the ring-oscillator RNG: warms the source up, decimates and health-tests
// its samples, and assembles OUT_WORDS of them into one word delivered over valid/ready.
module rng_harvester #(
  parameter int OUT_WORDS = 4,
  parameter int DECIM     = 4,
  parameter int WARMUP    = 16,
  parameter int REP_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      force_odd,
  output logic                      rng_en,
  input  logic [31:0]               rng_in,
  output logic [32*OUT_WORDS-1:0]   rnd_out,
  output logic                      rnd_valid,
  input  logic                      rnd_ready,
  output logic                      busy,
  output logic                      health_err
);

  localparam int DATA_W = 32;
  localparam int OUT_W  = DATA_W * OUT_WORDS;
  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int DEC_W  = $clog2(DECIM + 1);
  localparam int WORD_W = $clog2(OUT_WORDS + 1);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);

  localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(WARMUP - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST   = DEC_W'(DECIM - 1);
  localparam logic [WORD_W-1:0] WORDS_FULL = WORD_W'(OUT_WORDS);
  localparam logic [WORD_W-1:0] WORDS_LAST = WORD_W'(OUT_WORDS - 1);
  localparam logic [REP_W-1:0]  REP_MAX    = REP_W'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD,
    S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0]    rep_next;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                odd_q, odd_d;
  logic                rng_en_q, rng_en_d;
  logic [OUT_W-1:0]    rnd_out_q, rnd_out_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic                health_err_q, health_err_d;

  // All-zero / all-one samples indicate a stuck source and carry no entropy.
  function automatic logic is_stuck(input logic [DATA_W-1:0] s);
    return (s == '0) || (s == '1);
  endfunction

  // Prime-candidate form: odd, and full bit length.
  function automatic logic [OUT_W-1:0] prime_form(input logic [OUT_W-1:0] w);
    logic [OUT_W-1:0] r;
    r            = w;
    r[0]         = 1'b1;
    r[OUT_W-1]   = 1'b1;
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    dec_cnt_d    = dec_cnt_q;
    word_cnt_d   = word_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    rep_next     = rep_cnt_q;
    prev_d       = prev_q;
    odd_d        = odd_q;
    rng_en_d     = rng_en_q;
    rnd_out_d    = rnd_out_q;
    rnd_valid_d  = rnd_valid_q;
    health_err_d = health_err_q;

    case (state_q)
      S_IDLE, S_FAIL: begin
        if (start) begin
          odd_d        = force_odd;
          health_err_d = 1'b0;
          word_cnt_d   = '0;
          rep_cnt_d    = '0;
          warm_cnt_d   = '0;
          rng_en_d     = 1'b1;
          state_d      = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (warm_cnt_q == WARM_LAST) begin
          dec_cnt_d = '0;
          state_d   = S_COLLECT;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      S_COLLECT: begin
        if (word_cnt_q == WORDS_FULL) begin
          rnd_valid_d = 1'b1;
          rng_en_d    = 1'b0;
          state_d     = S_HOLD;
        end else begin
          dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + 1'b1;
          if ((dec_cnt_q == DEC_LAST) && !is_stuck(rng_in)) begin
            // rep_cnt_q == 0 marks the first stored sample since start.
            rep_next = ((rep_cnt_q != '0) && (rng_in == prev_q)) ? rep_cnt_q + 1'b1 : REP_W'(1);
            if (rep_next == REP_MAX) begin
              health_err_d = 1'b1;
              rng_en_d     = 1'b0;
              state_d      = S_FAIL;
            end else begin
              rep_cnt_d = rep_next;
              prev_d    = rng_in;
              for (int i = 0; i < OUT_WORDS; i++) begin
                if (word_cnt_q == WORD_W'(i)) rnd_out_d[i*DATA_W +: DATA_W] = rng_in;
              end
              if ((word_cnt_q == WORDS_LAST) && odd_q) rnd_out_d = prime_form(rnd_out_d);
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        if (rnd_valid_q && rnd_ready) begin
          rnd_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      warm_cnt_q   <= '0;
      dec_cnt_q    <= '0;
      word_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      prev_q       <= '0;
      odd_q        <= 1'b0;
      rng_en_q     <= 1'b0;
      rnd_out_q    <= '0;
      rnd_valid_q  <= 1'b0;
      health_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      dec_cnt_q    <= dec_cnt_d;
      word_cnt_q   <= word_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      prev_q       <= prev_d;
      odd_q        <= odd_d;
      rng_en_q     <= rng_en_d;
      rnd_out_q    <= rnd_out_d;
      rnd_valid_q  <= rnd_valid_d;
      health_err_q <= health_err_d;
    end
  end

  assign rng_en     = rng_en_q;
  assign rnd_out    = rnd_out_q;
  assign rnd_valid  = rnd_valid_q;
  assign health_err = health_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rng_harvester.sv
// Bench for rng_harvester: per-edge source tables, a queue-based model of which samples get
// kept, and checks of timing, word contents, health failure, stalls and reset.
module tb_rng_harvester;

  localparam int OUT_WORDS = 4;
  localparam int DECIM     = 4;
  localparam int WARMUP    = 16;
  localparam int REP_LIMIT = 3;
  localparam int OUT_W     = 32 * OUT_WORDS;
  localparam int MAXC      = 256;

  logic             clk = 1'b0;
  logic             rst_n, start, force_odd, rnd_ready;
  logic             rng_en, rnd_valid, busy, health_err;
  logic [31:0]      rng_in;
  logic [OUT_W-1:0] rnd_out;

  int n_tests = 0;
  int n_fail  = 0;

  // stim[k] is the source value present at the k-th rising edge after (and including) the start edge.
  logic [31:0] stim [MAXC];

  rng_harvester #(
    .OUT_WORDS(OUT_WORDS),
    .DECIM(DECIM),
    .WARMUP(WARMUP),
    .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .force_odd(force_odd),
    .rng_en(rng_en),
    .rng_in(rng_in),
    .rnd_out(rnd_out),
    .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready),
    .busy(busy),
    .health_err(health_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Candidates appear every DECIM edges once warm-up has elapsed; stuck values are dropped,
  // a run of REP_LIMIT identical kept values is a failure, OUT_WORDS kept values complete a word.
  task automatic model(input logic fo, output int end_edge, output logic fails, output logic [OUT_W-1:0] word);
    logic [31:0] kept [$];
    int run;
    end_edge = -1;
    fails    = 1'b0;
    word     = '0;
    for (int k = WARMUP + DECIM; k < MAXC; k += DECIM) begin
      if (stim[k] == 32'h0 || stim[k] == 32'hFFFF_FFFF) continue;
      run = 1;
      for (int j = kept.size() - 1; j >= 0 && kept[j] == stim[k]; j--) run++;
      if (run >= REP_LIMIT) begin
        fails    = 1'b1;
        end_edge = k;
        break;
      end
      kept.push_back(stim[k]);
      if (kept.size() == OUT_WORDS) begin
        foreach (kept[i]) word[32*i +: 32] = kept[i];
        if (fo) begin
          word[0]       = 1'b1;
          word[OUT_W-1] = 1'b1;
        end
        end_edge = k + 1;
        break;
      end
    end
  endtask

  task automatic run_txn(input string tag, input logic fo, input int hold, output int v_edge, output int e_edge);
    int               exp_end, en_err, stay_err;
    logic             exp_fail;
    logic [OUT_W-1:0] exp_word, held;
    model(fo, exp_end, exp_fail, exp_word);
    v_edge    = -1;
    e_edge    = -1;
    en_err    = 0;
    start     = 1'b1;
    force_odd = fo;
    rnd_ready = (hold == 0);
    rng_in    = stim[0];
    for (int k = 0; k <= exp_end; k++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      force_odd = 1'($urandom_range(0, 1));
      rng_in    = (k + 1 < MAXC) ? stim[k+1] : $urandom;
      if (k == 0) check_eq({tag, "_err_clr"}, OUT_W'(health_err), OUT_W'(0));
      if (rnd_valid === 1'b1 && v_edge < 0) v_edge = k;
      if (health_err === 1'b1 && e_edge < 0) e_edge = k;
      if (rng_en !== (k < exp_end)) en_err++;
    end
    check_eq({tag, "_rng_en"}, OUT_W'(en_err), OUT_W'(0));
    check_eq({tag, "_busy"}, OUT_W'(busy), OUT_W'(1));
    if (exp_fail) begin
      check_eq({tag, "_err_edge"}, OUT_W'(e_edge), OUT_W'(exp_end));
      check_eq({tag, "_no_valid"}, OUT_W'(v_edge), OUT_W'(-1));
      stay_err = 0;
      repeat (6) begin
        @(posedge clk); #1;
        rng_in = $urandom;
        if (rnd_valid !== 1'b0 || health_err !== 1'b1 || rng_en !== 1'b0 || busy !== 1'b1) stay_err++;
      end
      check_eq({tag, "_fail_stay"}, OUT_W'(stay_err), OUT_W'(0));
    end else begin
      check_eq({tag, "_valid_edge"}, OUT_W'(v_edge), OUT_W'(exp_end));
      check_eq({tag, "_no_err"}, OUT_W'(e_edge), OUT_W'(-1));
      check_eq({tag, "_word"}, rnd_out, exp_word);
      if (hold > 0) begin
        held     = rnd_out;
        stay_err = 0;
        for (int i = 0; i < hold; i++) begin
          @(posedge clk); #1;
          start  = (i == hold / 2);
          rng_in = $urandom;
          if (rnd_valid !== 1'b1 || rnd_out !== held || busy !== 1'b1 || rng_en !== 1'b0) stay_err++;
        end
        check_eq({tag, "_hold_stable"}, OUT_W'(stay_err), OUT_W'(0));
        start     = 1'b0;
        rnd_ready = 1'b1;
      end
      @(posedge clk); #1;
      check_eq({tag, "_valid_clr"}, OUT_W'(rnd_valid), OUT_W'(0));
      check_eq({tag, "_idle"}, OUT_W'(busy), OUT_W'(0));
      check_eq({tag, "_word_kept"}, rnd_out, exp_word);
    end
    rnd_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rng_en"}, OUT_W'(rng_en), OUT_W'(0));
    check_eq({tag, "_rnd_out"}, rnd_out, OUT_W'(0));
    check_eq({tag, "_valid"}, OUT_W'(rnd_valid), OUT_W'(0));
    check_eq({tag, "_busy"}, OUT_W'(busy), OUT_W'(0));
    check_eq({tag, "_err"}, OUT_W'(health_err), OUT_W'(0));
  endtask

  task automatic fill_random(input logic allow_bad);
    int r;
    for (int k = 0; k < MAXC; k++) begin
      r = $urandom_range(0, 15);
      if (allow_bad && r == 0)      stim[k] = 32'h0;
      else if (allow_bad && r == 1) stim[k] = 32'hFFFF_FFFF;
      else                          stim[k] = $urandom;
      if (allow_bad && k >= DECIM && (k % DECIM) == 0 && $urandom_range(0, 2) == 0) stim[k] = stim[k-DECIM];
    end
  endtask

  initial begin
    int v_edge, e_edge;
    rst_n     = 1'b0;
    start     = 1'b0;
    force_odd = 1'b0;
    rnd_ready = 1'b0;
    rng_in    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < MAXC; k++) stim[k] = 32'h10 + k;
    run_txn("inc", 1'b0, 0, v_edge, e_edge);
    // Counting the edge that samples start as the first, valid appears on edge 1+WARMUP+DECIM*OUT_WORDS+1.
    check_eq("inc_latency", OUT_W'(v_edge + 1), OUT_W'(34));
    check_eq("inc_literal", rnd_out, {32'h30, 32'h2C, 32'h28, 32'h24});

    for (int k = 0; k < MAXC; k++) stim[k] = 32'h40 + 2 * k;
    run_txn("odd", 1'b1, 0, v_edge, e_edge);
    check_eq("odd_lsb", OUT_W'(rnd_out[0]), OUT_W'(1));
    check_eq("odd_msb", OUT_W'(rnd_out[OUT_W-1]), OUT_W'(1));
    check_eq("odd_literal", rnd_out, {32'h8000_0080, 32'h78, 32'h70, 32'h69});

    for (int k = 0; k < MAXC; k++) stim[k] = 32'hA5A5_A5A5;
    run_txn("rep", 1'b0, 0, v_edge, e_edge);
    check_eq("rep_third", OUT_W'(e_edge), OUT_W'(WARMUP + 3 * DECIM));

    fill_random(1'b0);
    run_txn("restart", 1'b0, 0, v_edge, e_edge);

    for (int k = 0; k < MAXC; k++) stim[k] = (k % 8 == 0) ? 32'h1000 + k : ((k % 2) ? 32'hFFFF_FFFF : 32'h0);
    run_txn("sparse", 1'b0, 0, v_edge, e_edge);
    check_eq("sparse_slow", OUT_W'(v_edge > WARMUP + DECIM * OUT_WORDS + 1), OUT_W'(1));
    check_eq("sparse_literal", rnd_out, {32'h1030, 32'h1028, 32'h1020, 32'h1018});

    fill_random(1'b0);
    run_txn("stall", 1'b0, 20, v_edge, e_edge);

    for (int k = 0; k < MAXC; k++) stim[k] = 32'h100 + k;
    start     = 1'b1;
    force_odd = 1'b0;
    rnd_ready = 1'b1;
    rng_in    = stim[0];
    for (int k = 0; k <= WARMUP + 2 * DECIM; k++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      rng_in = stim[k+1];
    end
    check_eq("abort_partial", OUT_W'(rnd_out[63:0]), OUT_W'({stim[WARMUP+2*DECIM], stim[WARMUP+DECIM]}));
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rnd_ready = 1'b0;
    fill_random(1'b0);
    run_txn("fresh", 1'b0, 0, v_edge, e_edge);

    for (int t = 0; t < 6; t++) begin
      fill_random(1'b1);
      run_txn($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), (t % 2) ? 4 : 0, v_edge, e_edge);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rng_harvester.md
Name: rng_harvester

Overview:
- Consumer side of the ring-oscillator RNG: drives its enable, samples its 32-bit output, runs online health tests, and assembles a wide random word.
- The output feeds the RSA prime-candidate path. With force_odd set, the word is forced odd with its MSB set.
- The result is delivered over a valid/ready handshake.

Parameters:
- OUT_WORDS, 4, number of 32-bit samples per output word (output width = 32*OUT_WORDS).
- DECIM, 4, cycles between accepted samples (≥1); reduces sample-to-sample correlation.
- WARMUP, 16, cycles after rng_en rises before the first sample is considered (≥1).
- REP_LIMIT, 3, number of consecutive identical accepted samples that declares a health failure (≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request for a new random word
- force_odd  in  1  sampled with start; when set, output bit 0 and MSB are forced to 1
- rng_en  out  1  enable to the RNG source
- rng_in  in  32  raw RNG sample (asynchronous-origin bits, already registered by the source)
- rnd_out  out  32*OUT_WORDS  assembled random word
- rnd_valid  out  1  rnd_out holds a complete word
- rnd_ready  in  1  consumer accepts rnd_out
- busy  out  1  high in any state other than IDLE
- health_err  out  1  sticky health-test failure flag

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. rng_en=0, rnd_out=0, rnd_valid=0, busy=0, health_err=0. All counters and the previous-sample register are cleared.
- States:
  - IDLE: start=1 latches force_odd, clears health_err, the word counter and the rep counter, sets rng_en=1, and goes to WARMUP. start outside IDLE is ignored.
  - WARMUP: counts WARMUP cycles, then goes to COLLECT with the decimation counter at 0.
  - COLLECT: the decimation counter runs 0..DECIM-1. On the cycle it equals DECIM-1, rng_in is a candidate sample. A candidate equal to 32'h0 or 32'hFFFFFFFF is discarded: not stored, not compared, no counter change.
  - Repetition test (COLLECT, stored candidates): a candidate equal to the previous stored sample increments the rep counter; a differing candidate resets it to 1. When the rep counter reaches REP_LIMIT, go to FAIL without storing that sample. The first stored sample after start sets the rep counter to 1.
  - Storage: each stored sample goes into word index = word counter, with index 0 in rnd_out[31:0]. The word counter then increments. When the stored sample is number OUT_WORDS, go to HOLD on the next edge. If the latched force_odd is set, bits 0 and 32*OUT_WORDS-1 are forced to 1 at that point.
  - HOLD: rnd_valid=1 and rng_en=0. rnd_out is stable while rnd_valid=1. On rnd_valid && rnd_ready, go to IDLE and clear rnd_valid on the following edge. rnd_out keeps its last value.
  - FAIL: rng_en=0 and health_err=1. No valid is produced and busy stays 1. The block leaves FAIL only through reset, or through start, which re-enters WARMUP and clears health_err and the counters.
- rnd_out is not updated outside COLLECT storage. Partial words are never presented.
- Minimum latency from the start edge to rnd_valid: 1 + WARMUP + DECIM*OUT_WORDS + 1 cycles. With defaults this is 34 cycles.
- Reset mid-operation aborts immediately to the reset values. No partial state survives.
- rnd_ready while rnd_valid=0 has no effect.

Test Plan:
- Defaults, rng_in incrementing by 1 each cycle starting at 32'h10, start with force_odd=0, rnd_ready=1:
  - rnd_valid rises exactly 34 cycles after start.
  - rnd_out is the four decimated values in order (word0 first); rng_en is 1 from the start edge until HOLD.
- Same run with force_odd=1 and source values chosen even with the top bit clear: rnd_out[0]=1, rnd_out[127]=1, and all other bits equal the collected samples.
- rng_in held at 32'hA5A5A5A5: the third accepted sample raises health_err. The state is FAIL, rnd_valid never asserts, and rng_en=0. A new start clears health_err and restarts WARMUP.
- rng_in alternating 32'h0 and 32'hFFFFFFFF except for one valid value every 8 cycles:
  - zeros and ones are never stored;
  - completion takes longer than the minimum;
  - no health_err is raised when the valid values are distinct.
- rnd_ready held 0 for 20 cycles in HOLD: rnd_valid and rnd_out stay stable, and a start pulse in HOLD is ignored. rnd_ready=1 then completes the transfer and returns busy=0 one cycle later.
- rst_n pulsed low mid-COLLECT (after 2 samples): all outputs return to reset values asynchronously. The next start produces a full fresh word with no leftover samples.
